// File: rtl/or_reduce_acc_n2t.sv
// ---------------------------------------------------------------------------
// or_reduce_acc_n2t
//
// Purpose:
//   Collects FRAME input words into a frame and presents the bitwise OR of
//   all of them (out_lanes) together with a one-bit flag (out_bit).
//   out_bit is the OR-reduction of out_lanes, or its inverse when the mode
//   latched on the first beat of the frame is 1 (NOR / zero detect).
//   Both sides use valid/ready handshakes. The result is held stable until
//   the consumer takes it, and completed handshakes are counted modulo 256.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset
//   flush        in   1      synchronous frame abort (wins over everything)
//   mode         in   1      flag sense: 0 = OR, 1 = NOR (sampled per frame)
//   in_valid     in   1      in_data holds a valid word
//   in_ready     out  1      block accepts a word this cycle
//   in_data      in   WIDTH  input word
//   out_valid    out  1      frame result is presented
//   out_ready    in   1      consumer takes the result this cycle
//   out_lanes    out  WIDTH  bitwise OR of all words of the frame
//   out_bit      out  1      OR-reduction of out_lanes, inverted when mode=1
//   frames_done  out  8      completed output handshakes, modulo 256
// ---------------------------------------------------------------------------
module or_reduce_acc_n2t #(
    parameter int WIDTH = 16,
    parameter int FRAME = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lanes,
    output logic             out_bit,
    output logic [7:0]       frames_done
);

    // Counter must be able to hold the value FRAME itself.
    localparam int CNT_W = (FRAME < 2) ? 1 : $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic [7:0]       frames_q;

    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] acc_d;

    // Flag of a finished frame: any set lane, optionally inverted.
    function automatic logic frame_flag(input logic [WIDTH-1:0] lanes,
                                        input logic             invert);
        return (|lanes) ^ invert;
    endfunction

    assign cnt_d = cnt_q + ONE_CNT;
    assign acc_d = acc_q | in_data;

    // ---------------------------------------------------------------------
    // Frame FSM. in_ready depends on state alone, so in IDLE/ACCUM an
    // asserted in_valid is an accepted beat.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            frames_q <= 8'd0;
        end else if (flush) begin
            // Abort discards the frame and any presented result; the
            // handshake counter is deliberately left untouched.
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_q   <= in_data;
                        mode_q  <= mode;
                        cnt_q   <= ONE_CNT;
                        // A one-word frame is complete on its first beat.
                        state_q <= (LAST_CNT == ONE_CNT) ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == LAST_CNT) begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_q  <= S_IDLE;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        frames_q <= frames_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs are decoded from registered state only; the result lanes are
    // masked so nothing leaks out while no result is presented.
    // ---------------------------------------------------------------------
    assign in_ready    = (state_q != S_HOLD);
    assign out_valid   = (state_q == S_HOLD);
    assign out_lanes   = out_valid ? acc_q : '0;
    assign out_bit     = out_valid & frame_flag(acc_q, mode_q);
    assign frames_done = frames_q;

endmodule

// File: tb/tb_or_reduce_acc_n2t.sv
module tb_or_reduce_acc_n2t;
    localparam int W = 16;
    localparam int F = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_lanes;
    logic         out_bit;
    logic [7:0]   frames_done;

    // Second build with one-word frames.
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [W-1:0] b_in_data = '0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [W-1:0] b_out_lanes;
    logic         b_out_bit;
    logic [7:0]   b_frames_done;
    logic         b_flush = 1'b0;
    logic         b_mode = 1'b0;

    or_reduce_acc_n2t #(.WIDTH(W), .FRAME(F)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_lanes(out_lanes),
        .out_bit(out_bit), .frames_done(frames_done)
    );

    or_reduce_acc_n2t #(.WIDTH(W), .FRAME(1)) dut_f1 (
        .clk(clk), .reset_n(reset_n), .flush(b_flush), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_lanes(b_out_lanes),
        .out_bit(b_out_bit), .frames_done(b_frames_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the words of the current frame in a queue, whether a
    // result is being held, the mode of the frame and the handshake count.
    logic [W-1:0] m_q[$];
    bit           m_hold = 1'b0;
    bit           m_mode = 1'b0;
    logic [7:0]   m_frames = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_or_all();
        logic [W-1:0] r = '0;
        foreach (m_q[i]) r = r | m_q[i];
        return r;
    endfunction

    task automatic model_edge();
        if (flush) begin
            m_q.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                m_frames = m_frames + 8'd1;
                m_q.delete();
            end
        end else if (in_valid) begin
            if (m_q.size() == 0) m_mode = mode;
            m_q.push_back(in_data);
            if (m_q.size() == F) m_hold = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [W-1:0] el;
        logic         eb;
        el = m_hold ? m_or_all() : '0;
        eb = m_hold ? ((el != '0) ^ m_mode) : 1'b0;
        chk("in_ready", in_ready, !m_hold);
        chk("out_valid", out_valid, m_hold);
        chk("out_lanes", out_lanes, el);
        chk("out_bit", out_bit, eb);
        chk("frames_done", frames_done, m_frames);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic beat(input logic [W-1:0] d, input logic md);
        in_valid = 1'b1;
        in_data  = d;
        mode     = md;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held_lanes;
        logic         held_bit;

        // Reset state, observed while reset is still asserted.
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_lanes", out_lanes, 16'h0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_frames", frames_done, 8'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_f1_valid", b_out_valid, 1'b0);
        #10 reset_n = 1'b1;
        cyc();

        // Four one-hot nibbles, back to back, OR mode.
        in_valid = 1'b1; mode = 1'b0;
        in_data = 16'h0001; cyc();
        in_data = 16'h0010; cyc();
        in_data = 16'h0100; cyc();
        chk("basic_not_yet", out_valid, 1'b0);
        in_data = 16'h1000; cyc();
        in_valid = 1'b0;
        chk("basic_valid", out_valid, 1'b1);
        chk("basic_lanes", out_lanes, 16'h1111);
        chk("basic_bit", out_bit, 1'b1);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        chk("basic_frames", frames_done, 8'd1);

        // Zero detect with mode toggled mid-frame.
        beat(16'h0000, 1'b1); beat(16'h0000, 1'b0);
        beat(16'h0000, 1'b1); beat(16'h0000, 1'b0);
        chk("nor_lanes", out_lanes, 16'h0000);
        chk("nor_bit_zero", out_bit, 1'b1);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        beat(16'h0000, 1'b1); beat(16'h8000, 1'b0);
        beat(16'h0000, 1'b0); beat(16'h0000, 1'b1);
        chk("nor_bit_set", out_bit, 1'b0);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;

        // Back-pressure in HOLD with in_valid kept high.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = W'($urandom); cyc();
        end
        held_lanes = out_lanes;
        held_bit   = out_bit;
        for (int i = 0; i < 5; i++) begin
            in_data = W'($urandom); cyc();
            chk("bp_lanes_stable", out_lanes, held_lanes);
            chk("bp_bit_stable", out_bit, held_bit);
        end
        chk("bp_frames_hold", frames_done, 8'd3);
        out_ready = 1'b1; cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_frames_after", frames_done, 8'd4);
        cyc();

        // Flush after two beats, coincident with a third.
        beat(16'hFFFF, 1'b0); beat(16'h00F0, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h0F0F; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) beat(16'h0002, 1'b0);
        chk("flush_clean_lanes", out_lanes, 16'h0002);
        // Flush beats a coincident output handshake.
        flush = 1'b1; out_ready = 1'b1; cyc();
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_no_count", frames_done, 8'd4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom) & W'($urandom) & W'($urandom);
            if ($urandom_range(0, 3) == 0) in_data = '0;
            mode      = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            cyc();
        end
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cyc();
        flush = 1'b0;

        // Get a frame into HOLD, then reset asynchronously between edges.
        beat(16'h0001, 1'b0); beat(16'h0002, 1'b0);
        beat(16'h0004, 1'b0); beat(16'h0008, 1'b0);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        beat(16'h0001, 1'b0); beat(16'h0002, 1'b0);
        beat(16'h0004, 1'b0); beat(16'h0008, 1'b0);
        chk("pre_rst_valid", out_valid, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        m_q.delete(); m_hold = 1'b0; m_mode = 1'b0; m_frames = 8'd0;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_frames", frames_done, 8'd0);
        chk("async_rst_lanes", out_lanes, 16'h0);
        #2 reset_n = 1'b1;
        cyc();
        chk("post_rst_ready", in_ready, 1'b1);

        // 256 frames with the consumer always ready: counter wraps to 0.
        in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0;
        for (int i = 0; i < 256 * (F + 1); i++) begin
            in_data = W'($urandom);
            cyc();
            if (i == 255 * (F + 1) - 1) chk("wrap_255", frames_done, 8'd255);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("wrap_0", frames_done, 8'd0);

        // One-word frames.
        b_in_valid = 1'b1; b_in_data = 16'hA000; cyc();
        b_in_valid = 1'b0;
        chk("f1_valid_a", b_out_valid, 1'b1);
        chk("f1_lanes_a", b_out_lanes, 16'hA000);
        chk("f1_bit_a", b_out_bit, 1'b1);
        chk("f1_ready_hold", b_in_ready, 1'b0);
        b_out_ready = 1'b1; cyc(); b_out_ready = 1'b0;
        chk("f1_released", b_out_valid, 1'b0);
        b_in_valid = 1'b1; b_in_data = 16'h0000; cyc();
        b_in_valid = 1'b0;
        chk("f1_valid_b", b_out_valid, 1'b1);
        chk("f1_bit_b", b_out_bit, 1'b0);
        b_out_ready = 1'b1; cyc(); b_out_ready = 1'b0;
        chk("f1_frames", b_frames_done, 8'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/or_reduce_acc_n2t.md
OR_REDUCE_ACC_N2T -- requirements
Module: or_reduce_acc_n2t

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data word width in bits (legal: 1..64).
REQ-002 Parameter FRAME, default 4, SHALL set the number of input words per frame (legal: 1..256).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 flush  input  1  SHALL be a synchronous frame abort.
REQ-006 mode  input  1  SHALL select the flag sense: 0 = OR, 1 = NOR (zero detect).
REQ-007 in_valid  input  1  SHALL indicate that in_data holds a valid word.
REQ-008 in_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-009 in_data  input  WIDTH  SHALL be the input word.
REQ-010 out_valid  output  1  SHALL indicate that a frame result is presented.
REQ-011 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-012 out_lanes  output  WIDTH  SHALL be the bitwise OR of all words in the frame.
REQ-013 out_bit  output  1  SHALL be the OR-reduction of out_lanes, inverted when the latched mode is 1.
REQ-014 frames_done  output  8  SHALL count completed output handshakes.

Function
REQ-015 The block SHALL implement three states: IDLE (count 0, no data), ACCUM (1..FRAME-1 words taken), HOLD (result presented).
REQ-016 A beat SHALL be accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL be combinational on state only, never on in_valid.
REQ-018 On the first beat of a frame the accumulator SHALL load in_data, and mode SHALL be latched for the whole frame; later mode changes SHALL have no effect until the next frame.
REQ-019 On each later beat the accumulator SHALL become accumulator OR in_data, and the word counter SHALL increment by 1.
REQ-020 On the beat that makes the count equal to FRAME, the state SHALL become HOLD, and out_valid SHALL be 1 from the next cycle; latency from the last beat to out_valid SHALL be 1 cycle.
REQ-021 With FRAME = 1, every accepted beat SHALL go from IDLE directly to HOLD.
REQ-022 In HOLD, out_lanes, out_bit and out_valid SHALL stay stable until out_valid and out_ready are both 1.
REQ-023 On the output handshake the state SHALL return to IDLE, the accumulator and counter SHALL clear, and frames_done SHALL increment modulo 256 (255 -> 0).
REQ-024 in_ready SHALL be 1 on the cycle after the output handshake; no beat SHALL be accepted in the handshake cycle itself.
REQ-025 out_lanes and out_bit SHALL be 0 whenever out_valid is 0.
REQ-026 flush = 1 SHALL return the block to IDLE on the next edge from any state, clear the accumulator and counter, and drop out_valid; frames_done SHALL stay unchanged.
REQ-027 flush SHALL take priority over a coincident beat acceptance and a coincident output handshake; neither event SHALL take effect.
REQ-028 An in_valid pulse while in_ready = 0 SHALL be ignored with no state change.

Reset
REQ-029 reset_n = 0 SHALL immediately force IDLE, accumulator 0, counter 0, latched mode 0, out_valid 0, out_lanes 0, out_bit 0 and frames_done 0, independent of clk.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial or presented result, and no output handshake SHALL be reported.
REQ-031 After reset_n deasserts, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-032 With WIDTH=16, FRAME=4, mode=0, words 0x0001, 0x0010, 0x0100, 0x1000 back-to-back -> out_valid 1 cycle after the 4th beat, out_lanes=0x1111, out_bit=1.
REQ-033 mode=1 on the first beat, then four 0x0000 words with mode toggled mid-frame -> out_lanes=0x0000, out_bit=1; repeat with one 0x8000 word -> out_bit=0.
REQ-034 out_ready held 0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, outputs stable, no beat lost or taken; frames_done +1 only after out_ready=1.
REQ-035 flush after 2 beats coincident with a 3rd beat -> IDLE, accumulator 0; the next 4 words of 0x0002 -> out_lanes=0x0002, with no trace of earlier data.
REQ-036 Asynchronous reset_n pulse between edges while in HOLD -> out_valid 0 immediately, frames_done=0; 256 completed frames -> frames_done wraps to 0.
REQ-037 FRAME=1 build, words 0xA000, 0x0000 -> two results: out_bit=1, then out_bit=0 (mode=0), each 1 cycle after its beat.
